// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle datapath controller: states, opcodes,
// mux/ALU codes and the packed control word driven onto the datapath.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned WAIT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_ERROR  = 4'd15
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // States that wait on mem_ready and are therefore guarded by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating mem_ready wait counter with timeout compare.
module mc_wait_timer
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic timeout_c_o
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (active_i && !mem_ready_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A ready on the limit cycle still wins, so the compare is gated by it.
  assign timeout_c_o = (TIMEOUT_CYCLES != 0) && active_i && !mem_ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle MIPS-style datapath with sticky fault
// reporting for illegal opcodes and memory bus timeouts.
module multi_cycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                alu_src_a,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [STATE_W-1:0]  state,
  output logic                instr_done,
  output logic                illegal_instr,
  output logic                bus_error
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   timeout;
  ctrl_t  ctrl;

  mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (state_d != state_q),
    .active_i    (is_wait_state(state_q)),
    .mem_ready_i (mem_ready),
    .timeout_c_o (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) begin state_d = ST_ERROR; bus_err_d = 1'b1; end
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      begin state_d = ST_ERROR; illegal_d = 1'b1; end
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_LW)      state_d = ST_MEMRD;
        else if (opcode == OP_SW) state_d = ST_MEMWR;
        else                      begin state_d = ST_ERROR; illegal_d = 1'b1; end
      end
      ST_MEMRD: begin
        if (mem_ready)    state_d = ST_MEMWB;
        else if (timeout) begin state_d = ST_ERROR; bus_err_d = 1'b1; end
      end
      ST_MEMWR: begin
        if (mem_ready)    state_d = ST_FETCH;
        else if (timeout) begin state_d = ST_ERROR; bus_err_d = 1'b1; end
      end
      ST_MEMWB:  state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Control word per state; enables are forced off while reset is held.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SHL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (!rst) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.mem_read      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.instr_done    = 1'b0;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign alu_src_a     = ctrl.alu_src_a;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign state         = state_q;
  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: each driven cycle queues the
// expected state, control word and fault flags, checked on the falling edge.
module tb_multi_cycle_control;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      ctrl;
    logic       ill;
    logic       berr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic       iord, alu_src_a, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       instr_done, illegal_instr, bus_error;

  ctrl_t obs;
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  localparam logic [5:0] O_R   = 6'b000000;
  localparam logic [5:0] O_LW  = 6'b100011;
  localparam logic [5:0] O_SW  = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100;
  localparam logic [5:0] O_ADI = 6'b001000;
  localparam logic [5:0] O_J   = 6'b000010;
  localparam logic [5:0] O_BAD = 6'b111111;

  multi_cycle_control #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .instr_done(instr_done), .illegal_instr(illegal_instr),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs.pc_write      = pc_write;
    obs.pc_write_cond = pc_write_cond;
    obs.ir_write      = ir_write;
    obs.reg_write     = reg_write;
    obs.mem_read      = mem_read;
    obs.mem_write     = mem_write;
    obs.iord          = iord;
    obs.alu_src_a     = alu_src_a;
    obs.reg_dst       = reg_dst;
    obs.mem_to_reg    = mem_to_reg;
    obs.alu_src_b     = alu_src_b;
    obs.alu_op        = alu_op;
    obs.pc_source     = pc_source;
    obs.instr_done    = instr_done;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Control word each state must present, written straight from the state table.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy, input logic in_rst);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      4'd1:  c.alu_src_b = 2'b11;
      4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      4'd4:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      4'd5:  begin c.mem_write = 1'b1; c.iord = 1'b1; c.instr_done = rdy; end
      4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01;
                   c.pc_write_cond = 1'b1; c.instr_done = 1'b1; end
      4'd9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd10: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      4'd11: begin c.pc_source = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; end
      default: c = '0;
    endcase
    if (in_rst) begin
      c.pc_write = 1'b0; c.pc_write_cond = 1'b0; c.ir_write = 1'b0; c.reg_write = 1'b0;
      c.mem_read = 1'b0; c.mem_write = 1'b0; c.instr_done = 1'b0;
    end
    return c;
  endfunction

  task automatic push_exp(input logic [3:0] est, input logic rdy, input logic in_rst,
                          input logic eill, input logic eberr);
    exp_t e;
    e.st   = est;
    e.ctrl = exp_ctrl(est, rdy, in_rst);
    e.ill  = eill;
    e.berr = eberr;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] est,
                      input logic eill = 1'b0, input logic eberr = 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    opcode    = op;
    mem_ready = rdy;
    push_exp(est, rdy, 1'b0, eill, eberr);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst       = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      push_exp(4'd0, mem_ready, 1'b1, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("ctrl", 32'(obs), 32'(e.ctrl));
      check_eq("illegal_instr", 32'(illegal_instr), 32'(e.ill));
      check_eq("bus_error", 32'(bus_error), 32'(e.berr));
    end
  end

  initial begin
    rst = 1'b0;
    opcode = O_R;
    mem_ready = 1'b0;

    #1;
    check_eq("rst_state_async", 32'(state), 32'd0);
    reset_cycles(2);

    // R-type, no stalls
    step(O_R, 1'b1, 4'd0);
    step(O_R, 1'b1, 4'd1);
    step(O_R, 1'b1, 4'd6);
    step(O_R, 1'b1, 4'd7);

    // lw with three stall cycles in MEMRD
    step(O_LW, 1'b1, 4'd0);
    step(O_LW, 1'b1, 4'd1);
    step(O_LW, 1'b0, 4'd2);
    step(O_LW, 1'b0, 4'd3);
    step(O_LW, 1'b0, 4'd3);
    step(O_LW, 1'b0, 4'd3);
    step(O_LW, 1'b1, 4'd3);
    step(O_LW, 1'b0, 4'd4);

    // sw with one stall, two fetch stalls first
    step(O_SW, 1'b0, 4'd0);
    step(O_SW, 1'b0, 4'd0);
    step(O_SW, 1'b1, 4'd0);
    step(O_SW, 1'b1, 4'd1);
    step(O_SW, 1'b1, 4'd2);
    step(O_SW, 1'b0, 4'd5);
    step(O_SW, 1'b1, 4'd5);

    // beq then j then addi
    step(O_BEQ, 1'b1, 4'd0);
    step(O_BEQ, 1'b1, 4'd1);
    step(O_BEQ, 1'b1, 4'd8);
    step(O_J,   1'b1, 4'd0);
    step(O_J,   1'b1, 4'd1);
    step(O_J,   1'b1, 4'd11);
    step(O_ADI, 1'b1, 4'd0);
    step(O_ADI, 1'b1, 4'd1);
    step(O_ADI, 1'b0, 4'd9);
    step(O_ADI, 1'b0, 4'd10);

    // illegal opcode: ERROR is sticky for 20 cycles
    step(O_BAD, 1'b1, 4'd0);
    step(O_BAD, 1'b1, 4'd1);
    for (int i = 0; i < 20; i++) step(O_BAD, 1'($urandom_range(0, 1)), 4'd15, 1'b1, 1'b0);
    reset_cycles(2);

    // fetch timeout at count 4
    for (int i = 0; i < 5; i++) step(O_R, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step(O_R, 1'($urandom_range(0, 1)), 4'd15, 1'b0, 1'b1);
    reset_cycles(1);

    // ready arriving exactly at count 4 still completes
    for (int i = 0; i < 4; i++) step(O_R, 1'b0, 4'd0);
    step(O_R, 1'b1, 4'd0);
    step(O_R, 1'b1, 4'd1);
    step(O_R, 1'b1, 4'd6);
    step(O_R, 1'b1, 4'd7);

    // MEMRD timeout
    step(O_LW, 1'b1, 4'd0);
    step(O_LW, 1'b1, 4'd1);
    step(O_LW, 1'b1, 4'd2);
    for (int i = 0; i < 5; i++) step(O_LW, 1'b0, 4'd3);
    step(O_LW, 1'b0, 4'd15, 1'b0, 1'b1);
    reset_cycles(1);

    // reset asserted mid-cycle during MEMWR
    step(O_SW, 1'b1, 4'd0);
    step(O_SW, 1'b1, 4'd1);
    step(O_SW, 1'b1, 4'd2);
    step(O_SW, 1'b0, 4'd5);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check_eq("memwr_before_rst", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("memwr_drop_on_rst", 32'(mem_write), 32'd0);
    check_eq("state_on_rst", 32'(state), 32'd0);
    push_exp(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset_cycles(1);
    step(O_R, 1'b1, 4'd0);
    step(O_R, 1'b1, 4'd1);

    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max mem_ready wait cycles (0 = timeout disabled, legal 0..255).
REQ-002 SHALL have: clk  in  1  system clock, rising-edge.
REQ-003 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have: opcode  in  6  instr[31:26] from instruction register.
REQ-005 SHALL have: mem_ready  in  1  memory access completes this cycle.
REQ-006 SHALL have: pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables.
REQ-007 SHALL have: iord, alu_src_a, reg_dst, mem_to_reg  out  1 each  mux selects.
REQ-008 SHALL have: alu_src_b  out  2 (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2); alu_op  out  2 (00 add, 01 sub, 10 funct); pc_source  out  2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 SHALL have: state  out  4  current state; instr_done  out  1  retire pulse; illegal_instr, bus_error  out  1 each  sticky faults.

Function
REQ-010 SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERROR=15; unlisted outputs 0/00 in each state.
REQ-011 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; ->DECODE when mem_ready, else stay.
REQ-012 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; opcode 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->ERROR with illegal_instr set.
REQ-013 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEMRD, sw->MEMWR.
REQ-014 MEMRD: mem_read=1, iord=1; ->MEMWB on mem_ready. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; ->FETCH.
REQ-015 MEMWR: mem_write=1, iord=1 held until mem_ready; ->FETCH on mem_ready.
REQ-016 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; ->ALUWB. ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; ->FETCH.
REQ-017 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1; ->FETCH.
REQ-018 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; ->ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; ->FETCH.
REQ-019 JUMP: pc_source=10, pc_write=1; ->FETCH.
REQ-020 instr_done SHALL be 1 for exactly the cycle in MEMWB, MEMWR with mem_ready, ALUWB, BRANCH, ADDIWB, or JUMP.
REQ-021 Latency: lw 5, sw 4, R-type/addi 4, beq/j 3 cycles, each mem_ready-wait adds 1 cycle.
REQ-022 8-bit wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR, increment each cycle there with mem_ready=0, saturate at 255.
REQ-023 When TIMEOUT_CYCLES!=0 and counter equals TIMEOUT_CYCLES with mem_ready=0, SHALL go ERROR next cycle, set bus_error; mem_ready=1 that cycle completes normally.
REQ-024 ERROR: all enables 0, state held, illegal_instr/bus_error held until reset.

Reset
REQ-025 rst low SHALL asynchronously force state=FETCH, counter=0, illegal_instr=0, bus_error=0.
REQ-026 While rst low, pc_write, ir_write, reg_write, mem_read, mem_write, pc_write_cond, instr_done SHALL be 0; selects show FETCH values.
REQ-027 Reset mid-instruction SHALL abandon it; first cycle after release SHALL be FETCH.

Structure
REQ-028 State encodings, opcode constants, alu_op/alu_src_b/pc_source codes SHALL live in shared package mc_ctrl_pkg.
REQ-029 Wait counter/timeout compare SHALL be sub-module mc_wait_timer; FSM and output decode stay in top.

Verification
REQ-030 mem_ready=1, opcode 000000 -> states 0,1,6,7,0; reg_write=1, reg_dst=1 in state 7; instr_done pulses once.
REQ-031 opcode 100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=iord=1 throughout, then MEMWB with mem_to_reg=1.
REQ-032 opcode 000100 then 000010 -> BRANCH with pc_write_cond=1, alu_op=01; JUMP with pc_source=10, pc_write=1.
REQ-033 opcode 111111 in DECODE -> ERROR (state=15), illegal_instr=1, all enables 0 for 20 cycles until rst low.
REQ-034 TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> ERROR on cycle 6 after entry, bus_error=1; repeat with mem_ready=1 on count 4 -> DECODE, no error.
REQ-035 rst low during MEMWR -> mem_write drops immediately; after release state=FETCH, flags 0.
